iter_div_unit: RTL and testbench

//  Parametrised multi-cycle radix-2 restoring integer divider for the EX stage (HI/LO divide path).

---
 rtl/div_pkg.sv | 38 +++
 rtl/div_clz.sv | 20 ++
 rtl/iter_div_unit.sv | 139 +++++++++++++
 tb/tb_iter_div_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider: FSM encodings, counter width helper,
// and the flag/response structs carried between accept and result.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int DIV_CNT_W     = $clog2(DIV_WIDTH_DEF + 1);

  // Flat state encodings used by the FSM register; the enum mirrors them for debug visibility.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_FIXUP = 3'd2;
  localparam logic [2:0] S_ZERO  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIXUP = 3'd2,
    ZERO  = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  typedef struct packed {
    logic signed_op;
    logic sign_a;
    logic sign_b;
  } div_req_t;

  typedef struct packed {
    logic valid;
    logic div_zero;
  } div_rsp_t;

  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_clz.sv
// Priority leading-zero counter; an all-zero input reports WIDTH.
module div_clz
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic [WIDTH-1:0] a,
  output logic [CNT_W-1:0] count
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/iter_div_unit.sv
// Radix-2 restoring integer divider (signed/unsigned) with divide-by-zero result and flush.
// Optional early-out that skips leading zero dividend bits: define DIV_EARLY_OUT_EN.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o,
  output div_state_e       state_dbg_o
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high.
  // in_valid_i needs no hold beyond that edge; out_valid_o stays high with stable data
  // until out_ready_i is seen, and never depends on out_ready_i.

  logic [2:0]       state;
  div_req_t         req_q;
  div_rsp_t         rsp_q;
  logic [WIDTH-1:0] rem_q, dq_q, b_q, quo_q, rmd_q;
  logic [CNT_W-1:0] cnt_q, cnt_init;
  logic [WIDTH-1:0] abs_a, abs_b, dq_init, q_res, r_res;
  logic             sign_a, sign_b, accept, div_by_zero, borrow;
  logic [WIDTH:0]   shifted, trial;

  assign sign_a      = signed_i & dividend_i[WIDTH-1];
  assign sign_b      = signed_i & divisor_i[WIDTH-1];
  assign abs_a       = sign_a ? -dividend_i : dividend_i;
  assign abs_b       = sign_b ? -divisor_i : divisor_i;
  assign div_by_zero = (divisor_i == '0);
  assign in_ready_o  = (state == S_IDLE) && !flush_i;
  assign accept      = in_valid_i && in_ready_o;

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  div_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
    .a     (abs_a),
    .count (lz)
  );

  // A zero dividend still runs one iteration so CALC is never empty.
  assign dq_init  = abs_a << lz;
  assign cnt_init = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : CNT_W'(WIDTH) - lz;
`else
  assign dq_init  = abs_a;
  assign cnt_init = CNT_W'(WIDTH);
`endif

  // dq_q shifts dividend bits out at the top and quotient bits in at the bottom.
  assign shifted = {rem_q, dq_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_q};
  assign borrow  = trial[WIDTH];

  assign q_res = (req_q.signed_op && (req_q.sign_a ^ req_q.sign_b)) ? -dq_q : dq_q;
  assign r_res = (req_q.signed_op && req_q.sign_a) ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      req_q <= '0;
      rsp_q <= '0;
      rem_q <= '0;
      dq_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
      rsp_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_q <= '{signed_op: signed_i, sign_a: sign_a, sign_b: sign_b};
            b_q   <= abs_b;
            dq_q  <= dq_init;
            cnt_q <= cnt_init;
            if (div_by_zero) begin
              rem_q <= dividend_i;   // raw dividend becomes the remainder
              state <= S_ZERO;
            end else begin
              rem_q <= '0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          dq_q  <= {dq_q[WIDTH-2:0], ~borrow};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          quo_q <= q_res;
          rmd_q <= r_res;
          rsp_q <= '{valid: 1'b1, div_zero: 1'b0};
          state <= S_DONE;
        end
        S_ZERO: begin
          quo_q <= '1;
          rmd_q <= rem_q;
          rsp_q <= '{valid: 1'b1, div_zero: 1'b1};
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            rsp_q <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o = rsp_q.valid;
  assign div_zero_o  = rsp_q.div_zero;
  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
  assign busy_o      = (state != S_IDLE);
  assign state_dbg_o = div_state_e'(state);

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed and randomised checks of iter_div_unit: reset, signed/unsigned results, latency,
// divide-by-zero, back-pressure and flush.
module tb_iter_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush_i, in_valid_i, in_ready_o, signed_i;
  logic [W-1:0] dividend_i, divisor_i, quotient_o, remainder_o;
  logic         out_valid_o, out_ready_i, div_zero_o, busy_o;
  div_pkg::div_state_e state_dbg;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  iter_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o),
    .busy_o      (busy_o),
    .state_dbg_o (state_dbg)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle index (accept cycle = 0) at which out_valid_o should first be high.
  function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] mag;
    int           n;
    if (b == '0) return 2;
    mag = (sgn && a[W-1]) ? -a : a;
    n = 0;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
    if (n == 0) n = 1;
    return n + 2;
`else
    if (b == '0) return 2;
    if (sgn) return W + 2;
    return W + 2;
`endif
  endfunction

  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb, qq, rr;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      q = qq[W-1:0];
      r = rr[W-1:0];
      z = 1'b0;
    end
  endtask

  // Driver: issue one op from a negedge, wait for its result, check it, complete the handshake.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, ":ready"}, W'(in_ready_o), W'(1));
    in_valid_i = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    @(negedge clk);
    in_valid_i = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
    signed_i   = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, W'(lat), W'(exp_lat(sgn, a, b)));
    check({tag, ":quotient"}, quotient_o, exp_q.pop_front());
    check({tag, ":remainder"}, remainder_o, exp_q.pop_front());
    check({tag, ":div_zero"}, W'(div_zero_o), W'(ez));
    if (out_ready_i) begin
      @(negedge clk);
      check({tag, ":valid_drop"}, W'(out_valid_o), W'(0));
    end
  endtask

  initial begin
    logic [W-1:0] a, b, q, r;
    logic         z, sgn;
    int           guard, seen;

    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0; out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst:out_valid", W'(out_valid_o), W'(0));
    check("rst:div_zero", W'(div_zero_o), W'(0));
    check("rst:busy", W'(busy_o), W'(0));
    check("rst:in_ready", W'(in_ready_o), W'(1));
    check("rst:quotient", quotient_o, '0);
    check("rst:remainder", remainder_o, '0);
    @(negedge clk);

    run_op("u100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
    run_op("s-7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0);
    run_op("s7_-2",     1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0);
    run_op("s_min_-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0);
    run_op("u_min_max", 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0);
    run_op("s-100_-7",  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0);
    run_op("u_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0);
    run_op("u5_9",      1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0);
    run_op("zero",      1'b1, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      1'b1);
    run_op("u5_1",      1'b0, 32'd5,         32'd1,         32'd5,         32'd0,         1'b0);

    // Back-pressure: result held for 10 cycles; a request presented meanwhile waits its turn.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    @(negedge clk);
    dividend_i = 32'd77; divisor_i = 32'd7;
    guard = 0;
    while (!out_valid_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("bp:valid", W'(out_valid_o), W'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp:hold_q", quotient_o, 32'd10);
      check("bp:hold_r", remainder_o, 32'd0);
      check("bp:hold_valid", W'(out_valid_o), W'(1));
      check("bp:in_ready_low", W'(in_ready_o), W'(0));
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    check("bp:valid_drop", W'(out_valid_o), W'(0));
    check("bp:idle", W'(busy_o), W'(0));
    check("bp:ready_again", W'(in_ready_o), W'(1));
    @(negedge clk);
    check("bp:next_accepted", W'(busy_o), W'(1));
    in_valid_i = 1'b0;
    guard = 0;
    while (!out_valid_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("bp:next_q", quotient_o, 32'd11);
    check("bp:next_r", remainder_o, 32'd0);
    @(negedge clk);

    // Flush in the middle of CALC.
    in_valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("fl_calc:busy_before", W'(busy_o), W'(1));
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("fl_calc:busy", W'(busy_o), W'(0));
    check("fl_calc:valid", W'(out_valid_o), W'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_o) seen++;
    end
    check("fl_calc:no_pulse", W'(seen), W'(0));
    run_op("fl_calc:9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // A request presented together with flush in IDLE is not taken.
    flush_i = 1'b1; in_valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd9; divisor_i = 32'd3;
    #1;
    check("fl_idle:in_ready", W'(in_ready_o), W'(0));
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_idle:busy", W'(busy_o), W'(0));

    // Flush while a result is held in DONE.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd8; divisor_i = 32'd2;
    @(negedge clk);
    in_valid_i = 1'b0;
    guard = 0;
    while (!out_valid_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("fl_done:valid", W'(out_valid_o), W'(1));
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("fl_done:valid_gone", W'(out_valid_o), W'(0));
    check("fl_done:busy", W'(busy_o), W'(0));
    out_ready_i = 1'b1;
    run_op("fl_done:9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Random sweep against the reference model.
    for (int i = 0; i < 20; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = (i == 0) ? '0 : $urandom;
      b   = W'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) b = -b;
      model(sgn, a, b, q, r, z);
      run_op($sformatf("rand%0d", i), sgn, a, b, q, r, z);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
